// File: rtl/ip4_sm_req.sv
// ip4_sm_req: initiator-side controller for one IP4 shared-memory bank.
// Buffers in-order loads/stores in a 2-entry FIFO and returns load data tagged.
module ip4_sm_req #(
  parameter int ADR_W  = 10,
  parameter int WORD_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [WORD_W-1:0] req_dat,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              bk_wen,
  output logic [ADR_W-1:0]  bk_adr,
  output logic [WORD_W-1:0] bk_dati,
  input  logic [WORD_W-1:0] bk_dato,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [WORD_W-1:0] rsp_dat,
  output logic [TAG_W-1:0]  rsp_tag
);

  logic              fifo_wr  [2];
  logic [ADR_W-1:0]  fifo_adr [2];
  logic [WORD_W-1:0] fifo_dat [2];
  logic [TAG_W-1:0]  fifo_tag [2];

  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              rd_inflight;
  logic [TAG_W-1:0]  inflight_tag;
  logic [ADR_W-1:0]  last_adr;
  logic [WORD_W-1:0] last_dat;

  logic              head_vld;
  logic              head_wr;
  logic [ADR_W-1:0]  head_adr;
  logic [WORD_W-1:0] head_dat;
  logic [TAG_W-1:0]  head_tag;
  logic              push;
  logic              issue_st;
  logic              issue_ld;
  logic              pop;

  assign head_vld = (count != 2'd0);
  assign head_wr  = fifo_wr[rd_ptr];
  assign head_adr = fifo_adr[rd_ptr];
  assign head_dat = fifo_dat[rd_ptr];
  assign head_tag = fifo_tag[rd_ptr];

  // Ready depends only on stored occupancy, so a full FIFO refuses even when the head pops.
  assign req_rdy  = rst_n && (count != 2'd2);
  assign push     = req_vld && req_rdy;

  // Loads wait for a free read slot and a free response register; stores never wait.
  assign issue_st = head_vld && head_wr;
  assign issue_ld = head_vld && !head_wr && !rd_inflight && (!rsp_vld || rsp_rdy);
  assign pop      = issue_st || issue_ld;

  assign bk_wen   = issue_st;
  assign bk_adr   = pop      ? head_adr : last_adr;
  assign bk_dati  = issue_st ? head_dat : last_dat;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]  <= req_wr;
      fifo_adr[wr_ptr] <= req_adr;
      fifo_dat[wr_ptr] <= req_dat;
      fifo_tag[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_adr <= '0;
      last_dat <= '0;
    end else begin
      if (pop)      last_adr <= head_adr;
      if (issue_st) last_dat <= head_dat;
    end
  end

  // Bank data is valid exactly one cycle after the load issued; a capture outranks a consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight  <= 1'b0;
      inflight_tag <= '0;
      rsp_vld      <= 1'b0;
      rsp_dat      <= '0;
      rsp_tag      <= '0;
    end else begin
      rd_inflight <= issue_ld;
      if (issue_ld) inflight_tag <= head_tag;
      if (rd_inflight) begin
        rsp_vld <= 1'b1;
        rsp_dat <= bk_dato;
        rsp_tag <= inflight_tag;
      end else if (rsp_vld && rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ip4_sm_req.sv
// tb_ip4_sm_req: directed bench for ip4_sm_req with a behavioural synchronous bank.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ip4_sm_req;
  localparam int ADR_W  = 10;
  localparam int WORD_W = 32;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_vld;
  logic              req_rdy;
  logic              req_wr;
  logic [ADR_W-1:0]  req_adr;
  logic [WORD_W-1:0] req_dat;
  logic [TAG_W-1:0]  req_tag;
  logic              bk_wen;
  logic [ADR_W-1:0]  bk_adr;
  logic [WORD_W-1:0] bk_dati;
  logic [WORD_W-1:0] bk_dato;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [WORD_W-1:0] rsp_dat;
  logic [TAG_W-1:0]  rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] mem [0:(1<<ADR_W)-1];

  always #5 clk = ~clk;

  ip4_sm_req #(.ADR_W(ADR_W), .WORD_W(WORD_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_wr  (req_wr),
    .req_adr (req_adr),
    .req_dat (req_dat),
    .req_tag (req_tag),
    .bk_wen  (bk_wen),
    .bk_adr  (bk_adr),
    .bk_dati (bk_dati),
    .bk_dato (bk_dato),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_dat (rsp_dat),
    .rsp_tag (rsp_tag)
  );

  // Single-port bank: synchronous write, synchronous read of the presented address.
  always @(posedge clk) begin
    if (bk_wen) mem[bk_adr] <= bk_dati;
    bk_dato <= mem[bk_adr];
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic wr, input logic [ADR_W-1:0] adr,
                               input logic [WORD_W-1:0] dat, input logic [TAG_W-1:0] tag);
    req_vld = vld;
    req_wr  = wr;
    req_adr = adr;
    req_dat = dat;
    req_tag = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int got;
    logic accept;

    for (int a = 0; a < (1 << ADR_W); a++) mem[a] = '0;
    bk_dato = '0;
    rst_n   = 1'b0;
    rsp_rdy = 1'b1;
    idle();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("in_reset_req_rdy", 64'(req_rdy), 64'(0));
    checkOutput("in_reset_rsp_vld", 64'(rsp_vld), 64'(0));
    checkOutput("in_reset_bk_wen", 64'(bk_wen), 64'(0));
    checkOutput("in_reset_bk_adr", 64'(bk_adr), 64'(0));
    checkOutput("in_reset_bk_dati", 64'(bk_dati), 64'(0));
    checkOutput("in_reset_rsp_dat", 64'(rsp_dat), 64'(0));
    checkOutput("in_reset_rsp_tag", 64'(rsp_tag), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("post_reset_req_rdy", 64'(req_rdy), 64'(1));

    // Store then load to the same address.
    applyStimulus(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 10'h005, 32'h0, 4'd3);
    @(negedge clk);
    checkOutput("st_wen", 64'(bk_wen), 64'(1));
    checkOutput("st_adr", 64'(bk_adr), 64'(10'h005));
    checkOutput("st_dati", 64'(bk_dati), 64'(32'hDEADBEEF));
    tick();
    idle();
    @(negedge clk);
    checkOutput("st_wen_one_cycle", 64'(bk_wen), 64'(0));
    checkOutput("ld_issue_adr", 64'(bk_adr), 64'(10'h005));
    checkOutput("ld_dati_held", 64'(bk_dati), 64'(32'hDEADBEEF));
    checkOutput("ld_rsp_early1", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("ld_rsp_early2", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("ld_rsp_vld", 64'(rsp_vld), 64'(1));
    checkOutput("ld_rsp_dat", 64'(rsp_dat), 64'(32'hDEADBEEF));
    checkOutput("ld_rsp_tag", 64'(rsp_tag), 64'(3));
    tick();
    @(negedge clk);
    checkOutput("ld_rsp_consumed", 64'(rsp_vld), 64'(0));
    tick();

    // Eight back-to-back stores, one issued per cycle.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) applyStimulus(1'b1, 1'b1, 10'(i), 32'h100 + 32'(i), 4'd0);
      else       idle();
      @(negedge clk);
      if (i < 8) checkOutput("burst_req_rdy", 64'(req_rdy), 64'(1));
      if (i > 0) begin
        checkOutput("burst_wen", 64'(bk_wen), 64'(1));
        checkOutput("burst_adr", 64'(bk_adr), 64'(i - 1));
        checkOutput("burst_dati", 64'(bk_dati), 64'(32'h100 + 32'(i - 1)));
      end
      tick();
    end
    @(negedge clk);
    checkOutput("burst_wen_end", 64'(bk_wen), 64'(0));
    tick();

    // Load back addresses 0..7 with tags 0..7.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (sent < 8) applyStimulus(1'b1, 1'b0, 10'(sent), 32'h0, 4'(sent));
      else          idle();
      @(negedge clk);
      if (rsp_vld) begin
        checkOutput("burst_rsp_dat", 64'(rsp_dat), 64'(32'h100 + 32'(got)));
        checkOutput("burst_rsp_tag", 64'(rsp_tag), 64'(4'(got)));
        got++;
      end
      accept = req_vld && req_rdy;
      tick();
      if (accept) sent++;
    end
    idle();
    checkOutput("burst_rsp_count", 64'(got), 64'(8));

    // Response backpressure with three loads; then a push attempt into a full FIFO.
    rsp_rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd0, 32'h0, 4'd8);
    tick();
    applyStimulus(1'b1, 1'b0, 10'd1, 32'h0, 4'd9);
    tick();
    applyStimulus(1'b1, 1'b0, 10'd2, 32'h0, 4'd10);
    tick();
    applyStimulus(1'b1, 1'b1, 10'h3FF, 32'hBAD0BAD0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_req_rdy_full", 64'(req_rdy), 64'(0));
      checkOutput("bp_rsp_vld_hold", 64'(rsp_vld), 64'(1));
      checkOutput("bp_rsp_dat_hold", 64'(rsp_dat), 64'(32'h100));
      checkOutput("bp_rsp_tag_hold", 64'(rsp_tag), 64'(8));
      checkOutput("bp_no_wen", 64'(bk_wen), 64'(0));
      tick();
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("full_pop_push_rdy", 64'(req_rdy), 64'(0));
    checkOutput("bp_ld1_issue_adr", 64'(bk_adr), 64'(1));
    tick();
    idle();
    @(negedge clk);
    checkOutput("full_pop_count1_rdy", 64'(req_rdy), 64'(1));
    checkOutput("bp_gap1", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("bp_rsp1_vld", 64'(rsp_vld), 64'(1));
    checkOutput("bp_rsp1_dat", 64'(rsp_dat), 64'(32'h101));
    checkOutput("bp_rsp1_tag", 64'(rsp_tag), 64'(9));
    checkOutput("bp_ld2_issue_adr", 64'(bk_adr), 64'(2));
    tick();
    @(negedge clk);
    checkOutput("bp_gap2", 64'(rsp_vld), 64'(0));
    checkOutput("bp_rejected_store", 64'(bk_wen), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("bp_rsp2_vld", 64'(rsp_vld), 64'(1));
    checkOutput("bp_rsp2_dat", 64'(rsp_dat), 64'(32'h102));
    checkOutput("bp_rsp2_tag", 64'(rsp_tag), 64'(10));
    tick();
    @(negedge clk);
    checkOutput("bp_drained", 64'(rsp_vld), 64'(0));
    checkOutput("bp_drained_wen", 64'(bk_wen), 64'(0));
    tick();

    // Head-of-line: a blocked load holds back the store queued behind it.
    rsp_rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd3, 32'h0, 4'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 10'd4, 32'h0, 4'd2);
    tick();
    applyStimulus(1'b1, 1'b1, 10'h020, 32'hCAFE0001, 4'd0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hol_store_stalled", 64'(bk_wen), 64'(0));
      checkOutput("hol_rsp_vld", 64'(rsp_vld), 64'(1));
      checkOutput("hol_rsp_dat", 64'(rsp_dat), 64'(32'h103));
      checkOutput("hol_rsp_tag", 64'(rsp_tag), 64'(1));
      tick();
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("hol_ld_issue_wen", 64'(bk_wen), 64'(0));
    checkOutput("hol_ld_issue_adr", 64'(bk_adr), 64'(4));
    tick();
    @(negedge clk);
    checkOutput("hol_st_wen", 64'(bk_wen), 64'(1));
    checkOutput("hol_st_adr", 64'(bk_adr), 64'(10'h020));
    checkOutput("hol_st_dati", 64'(bk_dati), 64'(32'hCAFE0001));
    checkOutput("hol_rsp_gap", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("hol_rsp2_vld", 64'(rsp_vld), 64'(1));
    checkOutput("hol_rsp2_dat", 64'(rsp_dat), 64'(32'h104));
    checkOutput("hol_rsp2_tag", 64'(rsp_tag), 64'(2));
    tick();

    // Reset in the cycle after a load issues; the read must vanish.
    applyStimulus(1'b1, 1'b0, 10'h005, 32'h0, 4'd5);
    tick();
    idle();
    @(negedge clk);
    checkOutput("rst_ld_issue_adr", 64'(bk_adr), 64'(10'h005));
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_req_rdy", 64'(req_rdy), 64'(0));
    checkOutput("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    checkOutput("rst_bk_wen", 64'(bk_wen), 64'(0));
    checkOutput("rst_bk_adr", 64'(bk_adr), 64'(0));
    checkOutput("rst_bk_dati", 64'(bk_dati), 64'(0));
    checkOutput("rst_rsp_dat", 64'(rsp_dat), 64'(0));
    checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("rst_release_req_rdy", 64'(req_rdy), 64'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rst_no_ghost_rsp", 64'(rsp_vld), 64'(0));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 10'h020, 32'h0, 4'd7);
    tick();
    idle();
    @(negedge clk);
    checkOutput("rst_new_ld_early1", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("rst_new_ld_early2", 64'(rsp_vld), 64'(0));
    tick();
    @(negedge clk);
    checkOutput("rst_new_ld_vld", 64'(rsp_vld), 64'(1));
    checkOutput("rst_new_ld_dat", 64'(rsp_dat), 64'(32'hCAFE0001));
    checkOutput("rst_new_ld_tag", 64'(rsp_tag), 64'(7));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
